// File: rtl/dmem_responder.sv
// Responder end of the core data-memory interface: word-organised RAM plus a
// 16-byte MMIO window (tohost, 64-bit mtime, error counter). Loads are zero-latency.
module dmem_responder #(
   parameter int unsigned       XLEN      = 32,
   parameter int unsigned       DEPTH     = 1024,
   parameter logic [XLEN-1:0]   RAM_BASE  = 32'h0000_0000,
   parameter logic [XLEN-1:0]   MMIO_BASE = 32'h1000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            adr_v_i,
   input  logic [XLEN-1:0] adr_i,
   input  logic            is_store_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [2:0]      access_size_i,
   output logic [XLEN-1:0] load_data_o,
   output logic            tohost_v_o,
   output logic [XLEN-1:0] tohost_data_o,
   output logic            err_o,
   output logic [15:0]     err_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = XLEN / 8;

   logic [XLEN-1:0] mem [DEPTH];
   logic [63:0]     mtime;

   logic [1:0]      off;
   logic [1:0]      reg_sel;
   logic [AW-1:0]   widx;
   logic            size_ok;
   logic            misaligned;
   logic            ram_hit;
   logic            mmio_acc;
   logic            ro_store;
   logic            err_acc;
   logic            ld_ok;
   logic            st_ok;
   logic [NB-1:0]   size_be;
   logic [NB-1:0]   wr_be;
   logic [XLEN-1:0] size_mask;
   logic [XLEN-1:0] wr_data;
   logic [XLEN-1:0] ram_rd;
   logic [XLEN-1:0] mmio_rd;

   assign off     = adr_i[1:0];
   assign reg_sel = adr_i[3:2];
   assign widx    = adr_i[AW+1:2];

   always_comb begin
      size_ok   = 1'b1;
      size_be   = '0;
      size_mask = '0;
      case (access_size_i)
         3'b001: begin size_be = NB'(4'b0001); size_mask = XLEN'(8'hFF);   end
         3'b010: begin size_be = NB'(4'b0011); size_mask = XLEN'(16'hFFFF); end
         3'b100: begin size_be = '1;           size_mask = '1;              end
         default: size_ok = 1'b0;
      endcase
   end

   assign misaligned = (access_size_i == 3'b010 && off[0]) ||
                       (access_size_i == 3'b100 && off != 2'b00);
   assign ram_hit    = adr_i[XLEN-1:AW+2] == RAM_BASE[XLEN-1:AW+2];
   assign mmio_acc   = !ram_hit && (adr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4]);
   // mtime words are read-only; storing to them is an error, not a silent drop
   assign ro_store   = mmio_acc && is_store_i && (reg_sel == 2'd1 || reg_sel == 2'd2);
   assign err_acc    = adr_v_i && (!size_ok || misaligned || !(ram_hit || mmio_acc) ||
                                   (mmio_acc && access_size_i != 3'b100) || ro_store);
   assign ld_ok      = adr_v_i && !is_store_i && !err_acc;
   assign st_ok      = adr_v_i &&  is_store_i && !err_acc;

   assign wr_be   = size_be << off;
   assign wr_data = store_data_i << {off, 3'b000};
   assign ram_rd  = (mem[widx] >> {off, 3'b000}) & size_mask;

   always_comb begin
      case (reg_sel)
         2'd0:    mmio_rd = tohost_data_o;
         2'd1:    mmio_rd = mtime[31:0];
         2'd2:    mmio_rd = mtime[63:32];
         default: mmio_rd = XLEN'(err_cnt_o);
      endcase
   end

   always_comb begin
      load_data_o = '0;
      if (ld_ok) load_data_o = ram_hit ? ram_rd : mmio_rd;
   end

   always_ff @(posedge clk) begin
      if (st_ok && ram_hit) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mtime         <= '0;
         tohost_v_o    <= 1'b0;
         tohost_data_o <= '0;
         err_o         <= 1'b0;
         err_cnt_o     <= '0;
      end else begin
         mtime      <= mtime + 64'd1;
         tohost_v_o <= st_ok && mmio_acc && reg_sel == 2'd0;
         if (st_ok && mmio_acc && reg_sel == 2'd0) tohost_data_o <= store_data_i;
         if (err_acc) begin
            err_o <= 1'b1;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
         end else if (st_ok && mmio_acc && reg_sel == 2'd3) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random accesses checked against
// a byte-array reference model of the memory map and error rules.
module tb_dmem_responder;

   localparam int unsigned   DEPTH = 1024;
   localparam logic [31:0]   MMIO  = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        adr_v_i = 1'b0;
   logic [31:0] adr_i = '0;
   logic        is_store_i = 1'b0;
   logic [31:0] store_data_i = '0;
   logic [2:0]  access_size_i = 3'b100;
   logic [31:0] load_data_o;
   logic        tohost_v_o;
   logic [31:0] tohost_data_o;
   logic        err_o;
   logic [15:0] err_cnt_o;

   dmem_responder #(.XLEN(32), .DEPTH(DEPTH), .RAM_BASE(32'h0), .MMIO_BASE(MMIO)) dut (
      .clk(clk), .reset(reset), .adr_v_i(adr_v_i), .adr_i(adr_i), .is_store_i(is_store_i),
      .store_data_i(store_data_i), .access_size_i(access_size_i), .load_data_o(load_data_o),
      .tohost_v_o(tohost_v_o), .tohost_data_o(tohost_data_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [7:0]  ram_m [DEPTH*4];
   logic [31:0] tohost_m = '0;
   logic        tv_m = 1'b0;
   logic        err_m = 1'b0;
   logic [15:0] cnt_m = '0;
   logic [63:0] mt_m = '0;
   logic [31:0] last_ld;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive, check the combinational load, advance the model, check registers.
   task automatic step(input string tag, input bit rst, input bit v, input bit st,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      bit          legal, ram, mm, e;
      int          nb, r;
      logic [31:0] exp_ld;
      reset = rst; adr_v_i = v; is_store_i = st; adr_i = a; store_data_i = d; access_size_i = sz;
      legal = (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4);
      nb    = (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
      ram   = a < 4 * DEPTH;
      mm    = (a >> 4) == (MMIO >> 4);
      r     = int'((a >> 2) & 32'd3);
      e     = v && (!legal || (a % nb) != 0 || (!ram && !mm) || (mm && sz != 3'd4) ||
                    (mm && st && (r == 1 || r == 2)));
      exp_ld = '0;
      if (v && !st && !e) begin
         if (ram) begin
            for (int i = 0; i < nb; i++) exp_ld |= 32'(ram_m[int'(a) + i]) << (8 * i);
         end else begin
            case (r)
               0: exp_ld = tohost_m;
               1: exp_ld = mt_m[31:0];
               2: exp_ld = mt_m[63:32];
               default: exp_ld = {16'h0, cnt_m};
            endcase
         end
      end
      @(negedge clk);
      last_ld = load_data_o;
      chk({tag, ".load"}, load_data_o, exp_ld);
      if (rst) begin
         tohost_m = '0; tv_m = 1'b0; err_m = 1'b0; cnt_m = '0; mt_m = '0;
      end else begin
         mt_m = mt_m + 64'd1;
         tv_m = 1'b0;
         if (v && st && !e) begin
            if (ram) begin
               for (int i = 0; i < nb; i++) ram_m[int'(a) + i] = d[8*i +: 8];
            end else if (r == 0) begin
               tohost_m = d; tv_m = 1'b1;
            end else if (r == 3) begin
               cnt_m = '0; err_m = 1'b0;
            end
         end
         if (e) begin
            err_m = 1'b1;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".tohost_v"}, tohost_v_o, tv_m);
      chk({tag, ".tohost_data"}, tohost_data_o, tohost_m);
      chk({tag, ".err"}, err_o, err_m);
      chk({tag, ".err_cnt"}, err_cnt_o, cnt_m);
   endtask

   logic [31:0] ra, rd;
   logic [2:0]  rs;
   bit          rst_r, st_r, v_r;
   int          kind;

   initial begin
      @(posedge clk); #1;
      step("rst0", 1, 0, 0, 0, 0, 3'd4);
      step("rst1", 1, 0, 0, 0, 0, 3'd4);
      chk("reset.err_cnt", err_cnt_o, 16'h0);
      chk("reset.tohost", tohost_data_o, 32'h0);

      step("sw40", 0, 1, 1, 32'h40, 32'hA1B2C3D4, 3'd4);
      step("lb41", 0, 1, 0, 32'h41, 0, 3'd1);
      chk("lb41.const", last_ld, 32'hC3);
      step("lh42", 0, 1, 0, 32'h42, 0, 3'd2);
      chk("lh42.const", last_ld, 32'hA1B2);
      step("lw40", 0, 1, 0, 32'h40, 0, 3'd4);
      chk("lw40.const", last_ld, 32'hA1B2C3D4);
      step("sb43", 0, 1, 1, 32'h43, 32'hEE, 3'd1);
      step("lw40b", 0, 1, 0, 32'h40, 0, 3'd4);
      chk("sb43.const", last_ld, 32'hEEB2C3D4);
      step("sh40", 0, 1, 1, 32'h40, 32'h1234, 3'd2);
      step("lw40c", 0, 1, 0, 32'h40, 0, 3'd4);
      chk("sh40.const", last_ld, 32'hEEB21234);

      step("lw42mis", 0, 1, 0, 32'h42, 0, 3'd4);
      chk("lw42mis.const", last_ld, 32'h0);
      chk("lw42mis.cnt", err_cnt_o, 16'd1);
      step("sh41mis", 0, 1, 1, 32'h41, 32'h5555, 3'd2);
      chk("sh41mis.cnt", err_cnt_o, 16'd2);
      step("lw40d", 0, 1, 0, 32'h40, 0, 3'd4);
      chk("sh41mis.ram", last_ld, 32'hEEB21234);
      step("clr", 0, 1, 1, MMIO + 32'hC, 0, 3'd4);
      chk("clr.err", err_o, 1'b0);
      chk("clr.cnt", err_cnt_o, 16'd0);

      step("th1", 0, 1, 1, MMIO, 32'h1, 3'd4);
      chk("th1.v", tohost_v_o, 1'b1);
      step("idle", 0, 0, 0, 0, 0, 3'd4);
      chk("th1.pulse_end", tohost_v_o, 1'b0);
      step("th2a", 0, 1, 1, MMIO, 32'h7, 3'd4);
      step("th2b", 0, 1, 1, MMIO, 32'h9, 3'd4);
      chk("th2b.v", tohost_v_o, 1'b1);
      step("lwth", 0, 1, 0, MMIO, 0, 3'd4);
      step("sw_mtime_ro", 0, 1, 1, MMIO + 32'h4, 32'h3, 3'd4);
      step("lh_mmio", 0, 1, 0, MMIO, 0, 3'd2);
      step("mtlo", 0, 1, 0, MMIO + 32'h4, 0, 3'd4);
      step("mthi", 0, 1, 0, MMIO + 32'h8, 0, 3'd4);

      step("rst_mid", 1, 1, 1, MMIO, 32'h55, 3'd4);
      chk("rst_mid.tohost", tohost_data_o, 32'h0);
      step("mt_after_rst", 0, 1, 0, MMIO + 32'h4, 0, 3'd4);
      chk("mt_after_rst.const", last_ld, 32'h0);

      for (int w = 0; w < 16; w++) step("fill", 0, 1, 1, 32'(4 * w), $urandom, 3'd4);

      for (int n = 0; n < 600; n++) begin
         kind = $urandom_range(0, 11);
         rst_r = 1'b0; v_r = 1'b1; st_r = 1'($urandom_range(0, 1)); rd = $urandom;
         case ($urandom_range(0, 5))
            0:       rs = 3'($urandom_range(0, 7));
            1, 2:    rs = 3'd1;
            3:       rs = 3'd2;
            default: rs = 3'd4;
         endcase
         if (kind <= 6) begin
            ra = 32'($urandom_range(0, 63));
         end else if (kind <= 9) begin
            ra = MMIO + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) rs = 3'd4;
         end else if (kind == 10) begin
            ra = ($urandom_range(0, 1) != 0) ? 32'h2000_0000 + 32'($urandom_range(0, 255))
                                             : 32'h1000 + 32'($urandom_range(0, 255));
         end else begin
            ra = MMIO; rs = 3'd4; v_r = 1'($urandom_range(0, 1));
            rst_r = ($urandom_range(0, 9) == 0);
         end
         step("rand", rst_r, v_r, st_r, ra, rd, rs);
      end

      for (int n = 0; n < 65540; n++) step("sat", 0, 1, 0, 32'h42, 0, 3'd4);
      chk("sat.const", err_cnt_o, 16'hFFFF);
      step("sat_clr", 0, 1, 1, MMIO + 32'hC, 0, 3'd4);
      chk("sat_clr.const", err_cnt_o, 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
